// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared BCD constants and controller state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  // Controller states; there is no DONE state, done is a registered pulse.
  localparam int               ST_W    = 1;
  localparam logic [ST_W-1:0]  ST_IDLE = 1'b0;
  localparam logic [ST_W-1:0]  ST_ADD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Purpose  : Combinational one-digit BCD adder with decimal carry.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] x,
  input  logic [BCD_DIGIT_W-1:0] y,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   co
);

  // Binary sum is 5 bits wide: invalid digits can reach 15+15+1=31.
  logic [BCD_DIGIT_W:0] w_sum;

  // Binary add, then +6 correction whenever the sum exceeds a decimal digit.
  always_comb begin
    w_sum = {1'b0, x} + {1'b0, y} + {{BCD_DIGIT_W{1'b0}}, ci};
    if (w_sum > (BCD_DIGIT_W + 1)'(BCD_MAX)) begin
      // Adding 6 modulo 16 equals taking the low nibble of (sum + 6).
      digit = w_sum[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_CORR);
      co    = 1'b1;
    end else begin
      digit = w_sum[BCD_DIGIT_W-1:0];
      co    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder_ctrl
// Purpose  : Digit-serial packed-BCD adder, LSD first, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          err
);

  localparam int                c_W     = BCD_DIGIT_W * DIGITS;
  localparam int                c_CNT_W = $clog2(DIGITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIGITS - 1);

  logic [ST_W-1:0]        r_state, w_state_next;
  logic [c_CNT_W-1:0]     r_idx;
  logic [c_W-1:0]         r_opa, r_opb;
  logic                   r_carry, r_errp;
  logic [c_W-1:0]         r_sum;
  logic                   r_cout, r_err, r_done;
  logic                   w_busy, w_last, w_in_err, w_co;
  logic [BCD_DIGIT_W-1:0] w_digit;
  logic [c_W-1:0]         w_work_next;

  // The single shared digit adder always works on the current low digit.
  bcd_digit_add u_digit_add (
    .x     (r_opa[BCD_DIGIT_W-1:0]),
    .y     (r_opb[BCD_DIGIT_W-1:0]),
    .ci    (r_carry),
    .digit (w_digit),
    .co    (w_co)
  );

  assign w_last = (r_idx == c_LAST);

  // Flag any non-decimal digit in the operands as they are captured.
  always_comb begin
    w_in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX) ||
          b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX))
        w_in_err = 1'b1;
    end
  end

  // Working result: new digits enter at the top, so after DIGITS shifts
  // digit 0 has reached bits [3:0]. Only the upper digits need storage.
  generate
    if (DIGITS == 1) begin : g_work_single
      assign w_work_next = w_digit;
    end else begin : g_work_multi
      logic [c_W-BCD_DIGIT_W-1:0] r_work;

      assign w_work_next = {w_digit, r_work};

      // Clear on capture, shift one digit in per ADD cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_work <= '0;
        else if (r_state == ST_IDLE && start)
          r_work <= '0;
        else if (r_state == ST_ADD)
          r_work <= w_work_next[c_W-1:BCD_DIGIT_W];
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: start only matters in IDLE; leave ADD after the last digit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_ADD;
      ST_ADD:  if (w_last) w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_busy = (r_state == ST_ADD);
  end

  // Operand capture, digit sequencing and result/done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_errp  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_done <= 1'b0;
      if (start) begin
        r_opa   <= a;
        r_opb   <= b;
        r_carry <= cin;
        r_idx   <= '0;
        r_errp  <= w_in_err;
      end
    end else begin
      r_opa   <= r_opa >> BCD_DIGIT_W;
      r_opb   <= r_opb >> BCD_DIGIT_W;
      r_carry <= w_co;
      r_idx   <= r_idx + c_CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_work_next;
        r_cout <= w_co;
        r_err  <= r_errp;
        r_done <= 1'b1;
      end else begin
        r_done <= 1'b0;
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_adder_ctrl
// Purpose  : Directed self-checking bench for bcd_serial_adder_ctrl (4 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int total = 0;
  int bad   = 0;

  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; inputs are scrambled
  // right after the start edge to show that they were captured.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, output int lat, output int bcnt);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    int ndone = 0;
    #3 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (sum !== 16'h0)  begin bad++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    total++; if (cout !== 1'b0)  begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL idle_activity got=%0d exp=0", ndone); end
  endtask

  task automatic test_basic;
    int lat, bcnt;
    run_op(16'h1234, 16'h5678, 1'b1, lat, bcnt);
    total++; if (lat !== 4)        begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (bcnt !== 4)       begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bcnt); end
    total++; if (sum !== 16'h6913) begin bad++; $display("FAIL basic_sum got=%h exp=6913", sum); end
    total++; if (cout !== 1'b0)    begin bad++; $display("FAIL basic_cout got=%b exp=0", cout); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL basic_err got=%b exp=0", err); end
    @(negedge clk);
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (sum !== 16'h6913) begin bad++; $display("FAIL basic_sum_hold got=%h exp=6913", sum); end
  endtask

  task automatic test_carry;
    int lat, bcnt;
    run_op(16'h0999, 16'h0001, 1'b0, lat, bcnt);
    total++; if (sum !== 16'h1000) begin bad++; $display("FAIL carry1_sum got=%h exp=1000", sum); end
    total++; if (cout !== 1'b0)    begin bad++; $display("FAIL carry1_cout got=%b exp=0", cout); end
    run_op(16'h9999, 16'h0001, 1'b0, lat, bcnt);
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL carry2_sum got=%h exp=0000", sum); end
    total++; if (cout !== 1'b1)    begin bad++; $display("FAIL carry2_cout got=%b exp=1", cout); end
  endtask

  task automatic test_invalid;
    int lat, bcnt;
    run_op(16'h000A, 16'h0000, 1'b0, lat, bcnt);
    total++; if (sum !== 16'h0010) begin bad++; $display("FAIL inval_sum got=%h exp=0010", sum); end
    total++; if (cout !== 1'b0)    begin bad++; $display("FAIL inval_cout got=%b exp=0", cout); end
    total++; if (err !== 1'b1)     begin bad++; $display("FAIL inval_err got=%b exp=1", err); end
    run_op(16'h0001, 16'h0001, 1'b0, lat, bcnt);
    total++; if (sum !== 16'h0002) begin bad++; $display("FAIL valid_sum got=%h exp=0002", sum); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL valid_err got=%b exp=0", err); end
  endtask

  task automatic test_handshake;
    int n = 0;
    int extra = 0;
    @(negedge clk); a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 16'h4444; b = 16'h4444; start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL hs_early_done got=%b exp=0", done); end
    @(negedge clk);
    total++; if (done !== 1'b1)    begin bad++; $display("FAIL hs_done got=%b exp=1", done); end
    total++; if (sum !== 16'h3333) begin bad++; $display("FAIL hs_sum got=%h exp=3333", sum); end
    // Start in the done cycle must be accepted.
    a = 16'h0005; b = 16'h0004; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL hs_busy2 got=%b exp=1", busy); end
    total++; if (sum !== 16'h3333) begin bad++; $display("FAIL hs_sum_hold got=%h exp=3333", sum); end
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 4)          begin bad++; $display("FAIL hs_latency2 got=%0d exp=4", n); end
    total++; if (sum !== 16'h0009) begin bad++; $display("FAIL hs_sum2 got=%h exp=0009", sum); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL hs_queued_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_midop;
    int ndone = 0;
    int lat, bcnt;
    @(negedge clk); a = 16'h5555; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (sum !== 16'h0) begin bad++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b exp=0", cout); end
    total++; if (err !== 1'b0)  begin bad++; $display("FAIL midrst_err got=%b exp=0", err); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_done got=%0d exp=0", ndone); end
    run_op(16'h5555, 16'h5555, 1'b0, lat, bcnt);
    total++; if (lat !== 4)        begin bad++; $display("FAIL midrst_lat got=%0d exp=4", lat); end
    total++; if (sum !== 16'h1110) begin bad++; $display("FAIL midrst_sum2 got=%h exp=1110", sum); end
    total++; if (cout !== 1'b1)    begin bad++; $display("FAIL midrst_cout2 got=%b exp=1", cout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_invalid();
    test_handshake();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Sequencer that adds two multi-digit packed-BCD operands one digit per clock through a single shared one-digit BCD adder, least significant digit first, and propagates the decimal carry between digits. It sits between a register-file or host interface and arithmetic consumers. It trades latency for area against a fully parallel ripple of digit adders. It also uses a start/busy/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand (must be 1 or more); operand width is 4*DIGITS bits.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request pulse; sampled only while idle
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  carry into digit 0
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse; sum, cout and err are updated in this same cycle
sum  output  4*DIGITS  result, packed BCD; holds its value until the next done
cout  output  1  decimal carry out of the top digit
err  output  1  high if any captured digit of a or b was greater than 9

Behaviour:
- Reset (asynchronous): the state goes to IDLE. Outputs reset to busy=0, done=0, sum=0, cout=0, err=0. The working registers and the digit counter are cleared.
- States:
  - IDLE: busy=0.
  - ADD: busy=1.
  - No separate DONE state. done is a registered pulse, asserted on the edge that returns the block to IDLE.
- IDLE with start=1 at edge k:
  - a, b and cin are captured into the operand shift registers and the carry register.
  - The digit index is set to 0 and the state moves to ADD.
  - err_pending is computed from the captured digits.
- ADD, one digit per edge, at edges k+1 through k+DIGITS:
  - s = opA[3:0] + opB[3:0] + carry, computed 5 bits wide (maximum 9+9+1=19; 15+15+1=31 for invalid digits).
  - If s > 9: digit = (s+6)[3:0] and carry=1. Otherwise: digit = s[3:0] and carry=0.
  - The digit shifts into the working result from the top. The operands shift right by 4 and the index increments.
- At edge k+DIGITS (last digit):
  - sum <= final working result, cout <= final carry, err <= err_pending.
  - done=1 for exactly one cycle. The state returns to IDLE and busy falls.
- Latency: done is high in the DIGITS-th cycle after start is sampled. busy is high for DIGITS cycles. Throughput is one operation per DIGITS+1 cycles at most.
- start while busy: ignored. It is not queued.
- start while done=1: the block is already in IDLE, so start is accepted. The next done follows DIGITS cycles later.
- a, b and cin may change after the start edge without affecting the result.
- Invalid digits (greater than 9): the operation still completes using the rule above, and err=1 with that done. There is no other side effect.
- Reset mid-operation: the operation is aborted immediately and no done is produced. sum, cout and err return to 0.
- sum, cout and err change only at a done edge or at reset.

Decomposition:
- Shared include/package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=9, BCD_CORR=6.
  - State encodings ST_IDLE and ST_ADD.
- One sub-module, bcd_digit_add: purely combinational. Inputs are 4-bit x, 4-bit y and 1-bit ci. Outputs are a 4-bit digit and co, using the greater-than-9 rule above.
- The controller instantiates bcd_digit_add once and owns all sequential state: the state register, the digit counter ($clog2(DIGITS+1) bits), the operand shift registers, the carry register, the working result and err_pending.

Test Plan:
- Reset then idle: assert rst mid-cycle (asynchronous) -> busy=0, done=0, sum=0x0000, cout=0, err=0 immediately. Hold start=0 for 10 cycles -> no done.
- Basic add: a=0x1234, b=0x5678, cin=1, start pulse -> done exactly 4 cycles later with sum=0x6913, cout=0, err=0. busy is high for exactly 4 cycles.
- Carry ripple: a=0x0999, b=0x0001, cin=0 -> sum=0x1000, cout=0. Then a=0x9999, b=0x0001 -> sum=0x0000, cout=1.
- Invalid digit: a=0x000A, b=0x0000, cin=0 -> sum=0x0010, cout=0, err=1. The next valid add (0x0001+0x0001) -> err=0, sum=0x0002.
- Handshake: pulse start again 2 cycles into busy with different operands -> ignored and the first result is unchanged. Assert start in the done cycle -> accepted, with the second done 4 cycles later.
- Reset mid-op: start with 0x5555+0x5555, assert rst at cycle 2 -> no done. Outputs are 0. A fresh start afterwards gives sum=0x1110, cout=1.
